// File: rtl/hazard_controller_if.sv
// Hazard-controller bundle: pipeline hazard qualifiers in, per-register stall/flush and stats out.
// master = pipeline side driving the qualifiers, slave = hazard_controller.
interface hazard_controller_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned STAT_W = 32
);
  logic              ic_miss;
  logic              dc_miss;
  logic              ex_mispredict;
  logic              d_valid;
  logic              d_uses_rs;
  logic              d_uses_rt;
  logic [REG_AW-1:0] d_rs_addr;
  logic [REG_AW-1:0] d_rt_addr;
  logic              ex_is_load;
  logic [REG_AW-1:0] ex_rw_addr;

  logic              i2i_stall;
  logic              i2d_stall;
  logic              i2d_flush;
  logic              d2e_stall;
  logic              d2e_flush;
  logic              e2m_stall;
  logic              e2m_flush;
  logic              m2w_stall;
  logic              m2w_flush;
  logic [STAT_W-1:0] stat_stall_cycles;
  logic [STAT_W-1:0] stat_flushes;

  modport master (
    output ic_miss, dc_miss, ex_mispredict,
    output d_valid, d_uses_rs, d_uses_rt, d_rs_addr, d_rt_addr,
    output ex_is_load, ex_rw_addr,
    input  i2i_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush,
    input  e2m_stall, e2m_flush, m2w_stall, m2w_flush,
    input  stat_stall_cycles, stat_flushes
  );

  modport slave (
    input  ic_miss, dc_miss, ex_mispredict,
    input  d_valid, d_uses_rs, d_uses_rt, d_rs_addr, d_rt_addr,
    input  ex_is_load, ex_rw_addr,
    output i2i_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush,
    output e2m_stall, e2m_flush, m2w_stall, m2w_flush,
    output stat_stall_cycles, stat_flushes
  );
endinterface

// File: rtl/hazard_controller.sv
// Five-stage pipeline hazard controller: prioritised stall/flush generation plus redirect tracking.
// Optional saturating stall/flush counters are built only when HAZARD_STATS_EN is defined.
module hazard_controller #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned STAT_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  hazard_controller_if.slave hz
);

  typedef enum logic {
    RUN,
    REDIRECT_WAIT
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_load_use;

  logic w_i2i_stall;
  logic w_i2d_stall;
  logic w_i2d_flush;
  logic w_d2e_stall;
  logic w_d2e_flush;
  logic w_e2m_stall;
  logic w_m2w_flush;

  assign w_rs_hit   = hz.d_uses_rs && (hz.d_rs_addr == hz.ex_rw_addr);
  assign w_rt_hit   = hz.d_uses_rt && (hz.d_rt_addr == hz.ex_rw_addr);
  assign w_load_use = hz.d_valid && hz.ex_is_load && (hz.ex_rw_addr != '0)
                      && (w_rs_hit || w_rt_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A pending d-cache miss freezes everything, including the redirect tracker.
  always_comb begin
    w_next_state = r_state;
    if (hz.dc_miss) begin
      w_next_state = r_state;
    end else if (hz.ex_mispredict) begin
      w_next_state = hz.ic_miss ? REDIRECT_WAIT : RUN;
    end else if (r_state == REDIRECT_WAIT) begin
      w_next_state = hz.ic_miss ? REDIRECT_WAIT : RUN;
    end else begin
      w_next_state = RUN;
    end
  end

  always_comb begin
    w_i2i_stall = 1'b0;
    w_i2d_stall = 1'b0;
    w_i2d_flush = 1'b0;
    w_d2e_stall = 1'b0;
    w_d2e_flush = 1'b0;
    w_e2m_stall = 1'b0;
    w_m2w_flush = 1'b0;
    if (hz.dc_miss) begin
      w_i2i_stall = 1'b1;
      w_i2d_stall = 1'b1;
      w_d2e_stall = 1'b1;
      w_e2m_stall = 1'b1;
      w_m2w_flush = 1'b1;
    end else if (hz.ex_mispredict) begin
      w_i2d_flush = 1'b1;
      w_d2e_flush = 1'b1;
    end else if (r_state == REDIRECT_WAIT) begin
      // Wrong-path fetch data keeps being squashed until the i-cache delivers.
      w_i2d_flush = 1'b1;
      w_i2i_stall = hz.ic_miss;
    end else if (w_load_use) begin
      w_i2i_stall = 1'b1;
      w_i2d_stall = 1'b1;
      w_d2e_flush = 1'b1;
    end else if (hz.ic_miss) begin
      w_i2i_stall = 1'b1;
      w_i2d_flush = 1'b1;
    end
  end

  assign hz.i2i_stall = w_i2i_stall;
  assign hz.i2d_stall = w_i2d_stall;
  assign hz.i2d_flush = w_i2d_flush;
  assign hz.d2e_stall = w_d2e_stall;
  assign hz.d2e_flush = w_d2e_flush;
  assign hz.e2m_stall = w_e2m_stall;
  assign hz.e2m_flush = 1'b0;
  assign hz.m2w_stall = 1'b0;
  assign hz.m2w_flush = w_m2w_flush;

`ifdef HAZARD_STATS_EN
  logic              w_any_stall;
  logic              w_redirect_fire;
  logic [STAT_W-1:0] r_stall_cnt;
  logic [STAT_W-1:0] r_flush_cnt;

  assign w_any_stall     = w_i2i_stall || w_i2d_stall || w_d2e_stall || w_e2m_stall;
  assign w_redirect_fire = hz.ex_mispredict && !hz.dc_miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_any_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STAT_W'(1);
      end
      if (w_redirect_fire && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + STAT_W'(1);
      end
    end
  end

  assign hz.stat_stall_cycles = r_stall_cnt;
  assign hz.stat_flushes      = r_flush_cnt;
`else
  assign hz.stat_stall_cycles = '0;
  assign hz.stat_flushes      = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: priority rules, redirect wait, async reset, saturating stats.
// Output vector order: {i2i_s, i2d_s, i2d_f, d2e_s, d2e_f, e2m_s, e2m_f, m2w_s, m2w_f}.
module tb_hazard_controller;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned STAT_W = 4;

  localparam logic [8:0] O_NONE  = 9'b000000000;
  localparam logic [8:0] O_LOAD  = 9'b110010000;
  localparam logic [8:0] O_DMISS = 9'b110101001;
  localparam logic [8:0] O_MISP  = 9'b001010000;
  localparam logic [8:0] O_IMISS = 9'b101000000;
  localparam logic [8:0] O_RWAIT = 9'b001000000;

`ifdef HAZARD_STATS_EN
  localparam logic [31:0] EXP_STALLS  = 32'd15;
  localparam logic [31:0] EXP_FLUSHES = 32'd2;
`else
  localparam logic [31:0] EXP_STALLS  = 32'd0;
  localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  hazard_controller_if #(.REG_AW(REG_AW), .STAT_W(STAT_W)) hz_if ();

  hazard_controller #(.REG_AW(REG_AW), .STAT_W(STAT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {hz_if.i2i_stall, hz_if.i2d_stall, hz_if.i2d_flush,
            hz_if.d2e_stall, hz_if.d2e_flush, hz_if.e2m_stall,
            hz_if.e2m_flush, hz_if.m2w_stall, hz_if.m2w_flush};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    hz_if.ic_miss       = 1'b0;
    hz_if.dc_miss       = 1'b0;
    hz_if.ex_mispredict = 1'b0;
    hz_if.d_valid       = 1'b0;
    hz_if.d_uses_rs     = 1'b0;
    hz_if.d_uses_rt     = 1'b0;
    hz_if.d_rs_addr     = '0;
    hz_if.d_rt_addr     = '0;
    hz_if.ex_is_load    = 1'b0;
    hz_if.ex_rw_addr    = '0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    clear_inputs();

    #1;
    check_eq("reset_outs", 32'(outs()), 32'(O_NONE));
    check_eq("reset_stall_cnt", 32'(hz_if.stat_stall_cycles), 32'd0);
    check_eq("reset_flush_cnt", 32'(hz_if.stat_flushes), 32'd0);
    hz_if.ic_miss = 1'b1;
    #1;
    check_eq("reset_imiss_live", 32'(outs()), 32'(O_IMISS));
    hz_if.ic_miss = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use detection
    @(negedge clk);
    hz_if.ex_is_load = 1'b1; hz_if.ex_rw_addr = 5'd5;
    hz_if.d_valid = 1'b1; hz_if.d_uses_rs = 1'b1; hz_if.d_rs_addr = 5'd5;
    #1 check_eq("load_use_rs", 32'(outs()), 32'(O_LOAD));
    @(negedge clk);
    hz_if.ex_rw_addr = 5'd0; hz_if.d_rs_addr = 5'd0;
    #1 check_eq("load_use_r0", 32'(outs()), 32'(O_NONE));
    @(negedge clk);
    hz_if.d_uses_rs = 1'b0; hz_if.d_rs_addr = 5'd7;
    hz_if.d_uses_rt = 1'b1; hz_if.d_rt_addr = 5'd7; hz_if.ex_rw_addr = 5'd7;
    #1 check_eq("load_use_rt", 32'(outs()), 32'(O_LOAD));
    @(negedge clk);
    hz_if.d_uses_rt = 1'b0;
    #1 check_eq("load_use_unused_src", 32'(outs()), 32'(O_NONE));
    @(negedge clk);
    hz_if.d_uses_rt = 1'b1; hz_if.d_valid = 1'b0;
    #1 check_eq("load_use_invalid", 32'(outs()), 32'(O_NONE));
    @(negedge clk);
    hz_if.d_valid = 1'b1; hz_if.ic_miss = 1'b1;
    #1 check_eq("load_use_over_imiss", 32'(outs()), 32'(O_LOAD));
    @(negedge clk);
    clear_inputs();
    hz_if.ic_miss = 1'b1;
    #1 check_eq("imiss_only", 32'(outs()), 32'(O_IMISS));

    // D-cache miss masks a mispredict, which fires once the miss clears
    @(negedge clk);
    clear_inputs();
    hz_if.dc_miss = 1'b1; hz_if.ex_mispredict = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq($sformatf("dmiss_misp_c%0d", i), 32'(outs()), 32'(O_DMISS));
      @(negedge clk);
    end
    hz_if.dc_miss = 1'b0;
    #1 check_eq("misp_after_dmiss", 32'(outs()), 32'(O_MISP));
    @(negedge clk);
    hz_if.ex_mispredict = 1'b0;
    #1 check_eq("idle_after_misp", 32'(outs()), 32'(O_NONE));

    // Mispredict with i-cache miss enters redirect wait
    @(negedge clk);
    hz_if.ex_mispredict = 1'b1; hz_if.ic_miss = 1'b1;
    #1 check_eq("redir_enter", 32'(outs()), 32'(O_MISP));
    @(negedge clk);
    hz_if.ex_mispredict = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq($sformatf("redir_wait_c%0d", i), 32'(outs()), 32'(O_IMISS));
      @(negedge clk);
    end
    hz_if.ic_miss = 1'b0;
    #1 check_eq("redir_last_flush", 32'(outs()), 32'(O_RWAIT));
    @(negedge clk);
    #1 check_eq("redir_back_run", 32'(outs()), 32'(O_NONE));

    // Asynchronous reset while in redirect wait
    @(negedge clk);
    hz_if.ex_mispredict = 1'b1; hz_if.ic_miss = 1'b1;
    @(negedge clk);
    hz_if.ex_mispredict = 1'b0;
    #1 check_eq("pre_reset_wait", 32'(outs()), 32'(O_IMISS));
    #1;
    rst_n = 1'b0;
    hz_if.ic_miss = 1'b0;
    #1 check_eq("async_reset_run", 32'(outs()), 32'(O_NONE));
    check_eq("async_reset_stats", 32'(hz_if.stat_stall_cycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("post_reset_run", 32'(outs()), 32'(O_NONE));

    // Saturating statistics
    @(negedge clk);
    hz_if.dc_miss = 1'b1;
    repeat (20) @(negedge clk);
    hz_if.dc_miss = 1'b0;
    #1 check_eq("stat_stall_sat", 32'(hz_if.stat_stall_cycles), EXP_STALLS);
    check_eq("stat_flush_zero", 32'(hz_if.stat_flushes), 32'd0);
    hz_if.ex_mispredict = 1'b1;
    repeat (2) @(negedge clk);
    hz_if.ex_mispredict = 1'b0;
    #1 check_eq("stat_flush_cnt", 32'(hz_if.stat_flushes), EXP_FLUSHES);
    check_eq("stat_stall_held", 32'(hz_if.stat_stall_cycles), EXP_STALLS);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
